graded_note_lane: RTL and testbench
===================================

// Module: graded_note_lane
// PURPOSE
//  Parametrised note lane: shift register of note stages for one fret, with
//  advance-strobed scrolling, per-press hit grading (PERFECT/GOOD), a sustain
//  (tail) FSM, and a per-lane streak counter. It also renders the lane pixel.
//  One instance per fret sits between the chart reader and the score/HUD logic.
// PARAMETERS
//  NUM_STAGES    96   stage count (stage 0 = top/entry, NUM_STAGES-1 = exit)
//  STAGE_HEIGHT  5    pixel rows per stage
//  STRIPE_WIDTH  35   lane width in pixels
//  ZONE_START    83   first stage of the hit zone (inclusive)
//  ZONE_END      92   last stage of the hit zone (inclusive)
//  PERF_START    86   first PERFECT stage; requires ZONE_START<=PERF_START
//  PERF_END      89   last PERFECT stage; requires PERF_END<=ZONE_END
//  STREAK_W      8    streak counter width
// PORTS
//  clk            in  1   system clock
//  rst            in  1   synchronous, active-high reset
//  advance        in  1   scroll strobe; shift by one stage when 1
//  drop_note      in  2   00=none, 01=tail, 10=head; loaded into stage 0 on advance
//  mark_hit       in  1   strum pulse for this lane; one cycle long
//  button_held    in  1   fret button level
//  col,row        in  10  pixel coordinates
//  valid          in  1   active-video flag
//  lane_left_col  in  10  left pixel column of the lane
//  block_color    in  6   RRGGBB lane colour
//  lane_rgb       out 6   registered pixel colour
//  has_head_in_zone out 1 an unhit head is in [ZONE_START,ZONE_END]
//  has_tail_in_zone out 1 a tail is in the zone
//  hit_valid      out 1   pulse: a head was graded
//  hit_perfect    out 1   qualifies hit_valid: 1=PERFECT, 0=GOOD
//  ghost_press    out 1   pulse: mark_hit with no unhit head in the zone
//  note_missed    out 1   pulse: an unhit head left the last stage
//  sustain_tick   out 1   pulse: one or more tails cleared on this advance
//  sustain_broken out 1   pulse: button released while SUSTAIN and a tail is in the zone
//  streak         out STREAK_W  consecutive hits; saturating
// BEHAVIOUR
//  - Stage entry: {type[1:0], hit}. rst clears all stages, puts the FSM in
//    IDLE, and drives every output and streak to 0.
//  - Shifting happens only on advance=1: stage[i] <= stage[i-1]. Stage 0
//    takes {drop_note, 0}. A hit entry (head or tail) is replaced by
//    {00,0} when it shifts. A hit head therefore shows white for exactly
//    one stage period and is then removed.
//  - Miss: on advance, if stage[NUM_STAGES-1] holds an unhit head, then
//    note_missed=1 on the next cycle and streak<=0.
//  - Grading is evaluated every cycle, independent of advance. On mark_hit,
//    the unhit head with the highest index in the zone is selected. Only
//    that head gets hit=1. If mark_hit and advance coincide, the
//    post-shift index is graded and marked.
//    hit_valid=1 on the next cycle. hit_perfect = selected index in
//    [PERF_START,PERF_END]. streak increments, saturating at all-ones.
//    With no candidate head: ghost_press=1 on the next cycle. streak is
//    unchanged.
//  - A miss and a hit in the same cycle give streak=1 (the reset is applied
//    first, then the increment).
//  - Sustain FSM:
//    - IDLE->SUSTAIN on a graded hit.
//    - In SUSTAIN with button_held=1, every tail landing at stage
//      >=ZONE_START on advance gets hit=1, and sustain_tick pulses once for
//      that advance.
//    - SUSTAIN->IDLE when any of these occurs:
//      (a) button_held falls. sustain_broken pulses if has_tail_in_zone.
//      (b) An unhit head occupies the zone.
//      (c) The zone holds no heads and no tails.
//    - rst mid-sustain goes to IDLE with no pulses.
//  - All pulse outputs are 1 cycle wide and registered.
//  - Render pipeline (1-cycle latency):
//    - stage = row / STAGE_HEIGHT; rel_col = col - lane_left_col.
//    - Output 0 if !valid, if stage>=NUM_STAGES, or if rel_col>=STRIPE_WIDTH.
//    - Head: block_color, or 111111 if hit.
//    - Tail: only the centre 3 columns (STRIPE_WIDTH/2 +/-1); block_color,
//      or 111111 if hit.
//    - Empty stage: centre 3 columns drawn as 010101.
// TESTING
//  1 rst with all stages full -> the first cycle after rst shows every
//    output at 0, streak=0, and lane_rgb=0.
//  2 Head dropped, 88 advances -> it sits at stage 88. mark_hit ->
//    hit_valid=1, hit_perfect=1, streak=1. Next advance -> stage 89 is empty.
//  3 Head at stage 84, mark_hit -> hit_valid=1, hit_perfect=0.
//    mark_hit with an empty zone -> ghost_press=1, streak unchanged.
//  4 Head plus 6 tails, hit at 86, button held -> 6 sustain_tick pulses and
//    0 tails reach stage 93. Repeat with release after 2 ticks ->
//    sustain_broken=1, and the remaining tails pass through.
//  5 Streak at 255 (STREAK_W=8) plus a hit -> stays at 255. An unhit head
//    exiting stage 95 -> note_missed=1, streak=0. A hit in the same cycle
//    -> streak=1.
//  6 Render: STAGE_HEIGHT=5, head at stage 10, row=52, rel_col=0 -> lane_rgb
//    equals block_color one cycle later. With valid=0 -> lane_rgb=0.

Source files
------------

// File: rtl/graded_note_lane.sv
// graded_note_lane: scrolling note lane with hit grading, sustain tracking, streak counter and pixel render
module graded_note_lane #(
  parameter int NUM_STAGES   = 96,
  parameter int STAGE_HEIGHT = 5,
  parameter int STRIPE_WIDTH = 35,
  parameter int ZONE_START   = 83,
  parameter int ZONE_END     = 92,
  parameter int PERF_START   = 86,
  parameter int PERF_END     = 89,
  parameter int STREAK_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic [1:0]          drop_note,
  input  logic                mark_hit,
  input  logic                button_held,
  input  logic [9:0]          col,
  input  logic [9:0]          row,
  input  logic                valid,
  input  logic [9:0]          lane_left_col,
  input  logic [5:0]          block_color,
  output logic [5:0]          lane_rgb,
  output logic                has_head_in_zone,
  output logic                has_tail_in_zone,
  output logic                hit_valid,
  output logic                hit_perfect,
  output logic                ghost_press,
  output logic                note_missed,
  output logic                sustain_tick,
  output logic                sustain_broken,
  output logic [STREAK_W-1:0] streak
);
  localparam int SW = $clog2(NUM_STAGES);
  localparam int CTR = STRIPE_WIDTH / 2;
  typedef enum logic {IDLE, SUSTAIN} state_t;
  state_t state;
  logic [NUM_STAGES-1:0] head, tail, hit, sh_head, sh_tail, sh_hit, nx_hit, zone, deep, cand, land;
  logic [SW-1:0] sel, idx;
  logic graded, miss, sustaining, head_zone, tail_zone, leave, ctr;
  logic [9:0] rel_col;
  logic [5:0] pix;
  int st;
  always_comb begin
    zone = '0;
    deep = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      zone[i] = i >= ZONE_START && i <= ZONE_END;
      deep[i] = i >= ZONE_START;
    end
    sh_head = advance ? {head[NUM_STAGES-2:0] & ~hit[NUM_STAGES-2:0], drop_note == 2'b10} : head;
    sh_tail = advance ? {tail[NUM_STAGES-2:0] & ~hit[NUM_STAGES-2:0], drop_note == 2'b01} : tail;
    sh_hit = advance ? '0 : hit;
    cand = sh_head & ~sh_hit & zone;
    sel = '0;
    for (int i = 0; i < NUM_STAGES; i++) sel = cand[i] ? SW'(i) : sel;
    graded = mark_hit && |cand;
    sustaining = state == SUSTAIN && button_held && advance;
    land = sh_tail & deep;
    nx_hit = sh_hit | (sustaining ? land : '0) | (graded ? {{(NUM_STAGES-1){1'b0}}, 1'b1} << sel : '0);
    miss = advance && head[NUM_STAGES-1] && !hit[NUM_STAGES-1];
    head_zone = |(head & ~hit & zone);
    tail_zone = |(tail & zone);
    leave = !button_held || head_zone || !(|((head | tail) & zone));
    st = int'(row) / STAGE_HEIGHT;
    rel_col = col - lane_left_col;
    idx = st < NUM_STAGES ? SW'(st) : '0;
    ctr = int'(rel_col) >= CTR - 1 && int'(rel_col) <= CTR + 1;
    pix = (!valid || st >= NUM_STAGES || int'(rel_col) >= STRIPE_WIDTH) ? 6'd0
        : head[idx] ? (hit[idx] ? 6'h3f : block_color)
        : !ctr ? 6'd0
        : tail[idx] ? (hit[idx] ? 6'h3f : block_color)
        : 6'b010101;
  end
  assign has_head_in_zone = head_zone;
  assign has_tail_in_zone = tail_zone;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      hit <= '0;
      state <= IDLE;
      hit_valid <= 1'b0;
      hit_perfect <= 1'b0;
      ghost_press <= 1'b0;
      note_missed <= 1'b0;
      sustain_tick <= 1'b0;
      sustain_broken <= 1'b0;
      streak <= '0;
      lane_rgb <= '0;
    end else begin
      head <= sh_head;
      tail <= sh_tail;
      hit <= nx_hit;
      hit_valid <= graded;
      hit_perfect <= graded && int'(sel) >= PERF_START && int'(sel) <= PERF_END;
      ghost_press <= mark_hit && !(|cand);
      note_missed <= miss;
      sustain_tick <= sustaining && |land;
      sustain_broken <= state == SUSTAIN && !button_held && tail_zone;
      streak <= graded ? (miss ? STREAK_W'(1) : (&streak ? streak : streak + 1'b1)) : (miss ? '0 : streak);
      state <= graded ? SUSTAIN : (state == SUSTAIN && leave) ? IDLE : state;
      lane_rgb <= pix;
    end
  end
endmodule

// File: tb/tb_graded_note_lane.sv
// tb_graded_note_lane: directed scenarios plus randomized run against a note-list reference model
module tb_graded_note_lane;
  localparam int N = 96;
  localparam int ZS = 83;
  localparam int ZE = 92;
  localparam int PS = 86;
  localparam int PE = 89;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic advance = 1'b0;
  logic [1:0] drop_note = 2'b00;
  logic mark_hit = 1'b0;
  logic button_held = 1'b0;
  logic [9:0] col = 10'd0;
  logic [9:0] row = 10'd0;
  logic valid = 1'b0;
  logic [9:0] lane_left_col = 10'd100;
  logic [5:0] block_color = 6'b110000;
  logic [5:0] lane_rgb;
  logic has_head_in_zone, has_tail_in_zone, hit_valid, hit_perfect, ghost_press;
  logic note_missed, sustain_tick, sustain_broken;
  logic [7:0] streak;
  int tests = 0;
  int fails = 0;
  int mt [N];
  bit mhit [N];
  bit msus;
  int mstreak;
  bit e_hv, e_hp, e_gp, e_nm, e_tk, e_br;
  logic [5:0] e_rgb;

  graded_note_lane dut (
    .clk(clk), .rst(rst), .advance(advance), .drop_note(drop_note), .mark_hit(mark_hit),
    .button_held(button_held), .col(col), .row(row), .valid(valid), .lane_left_col(lane_left_col),
    .block_color(block_color), .lane_rgb(lane_rgb), .has_head_in_zone(has_head_in_zone),
    .has_tail_in_zone(has_tail_in_zone), .hit_valid(hit_valid), .hit_perfect(hit_perfect),
    .ghost_press(ghost_press), .note_missed(note_missed), .sustain_tick(sustain_tick),
    .sustain_broken(sustain_broken), .streak(streak)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_pix();
    int st;
    logic [9:0] rc;
    bit c;
    st = int'(row) / 5;
    rc = col - lane_left_col;
    c = int'(rc) >= 16 && int'(rc) <= 18;
    if (!valid || st >= N || int'(rc) >= 35) return 6'd0;
    if (mt[st] == 2) return mhit[st] ? 6'h3f : block_color;
    if (!c) return 6'd0;
    if (mt[st] == 1) return mhit[st] ? 6'h3f : block_color;
    return 6'b010101;
  endfunction

  function automatic bit zone_has(int typ, bit unhit_only);
    for (int i = ZS; i <= ZE; i++) if (mt[i] == typ && !(unhit_only && mhit[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update();
    bit hz, tz, az, miss;
    int best;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mt[i] = 0;
        mhit[i] = 1'b0;
      end
      msus = 1'b0;
      mstreak = 0;
      {e_hv, e_hp, e_gp, e_nm, e_tk, e_br} = '0;
      e_rgb = 6'd0;
      return;
    end
    e_rgb = model_pix();
    hz = zone_has(2, 1'b1);
    tz = zone_has(1, 1'b0);
    az = zone_has(2, 1'b0) || tz;
    e_br = msus && !button_held && tz;
    miss = advance && mt[N-1] == 2 && !mhit[N-1];
    if (advance) begin
      for (int i = N - 1; i > 0; i--) begin
        mt[i] = mhit[i-1] ? 0 : mt[i-1];
        mhit[i] = 1'b0;
      end
      mt[0] = drop_note == 2'b10 ? 2 : drop_note == 2'b01 ? 1 : 0;
      mhit[0] = 1'b0;
    end
    best = -1;
    for (int i = ZS; i <= ZE; i++) if (mt[i] == 2 && !mhit[i]) best = i;
    e_hv = mark_hit && best >= 0;
    e_hp = e_hv && best >= PS && best <= PE;
    e_gp = mark_hit && best < 0;
    e_nm = miss;
    e_tk = 1'b0;
    if (msus && button_held && advance)
      for (int i = ZS; i < N; i++) if (mt[i] == 1) begin
        mhit[i] = 1'b1;
        e_tk = 1'b1;
      end
    if (e_hv) mhit[best] = 1'b1;
    if (miss) mstreak = 0;
    if (e_hv && mstreak < 255) mstreak++;
    if (e_hv) msus = 1'b1;
    else if (msus && (!button_held || hz || !az)) msus = 1'b0;
  endtask

  task automatic step(input bit adv, input logic [1:0] dn, input bit mk, input bit bh);
    advance = adv;
    drop_note = dn;
    mark_hit = mk;
    button_held = bh;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 2'b00, 0, 0);
    step(0, 2'b00, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    valid = 1'b1;
    row = 10'd0;
    col = 10'd117;
    repeat (96) step(1, 2'b10, 0, 1);
    step(0, 2'b00, 1, 1);
    step(0, 2'b00, 1, 1);
    tests++;
    if (streak !== 8'd2) begin fails++; $display("FAIL reset_prefill_streak: got %0d want 2", streak); end
    rst = 1'b1;
    step(1, 2'b10, 1, 1);
    rst = 1'b0;
    tests++;
    if ({hit_valid, hit_perfect, ghost_press, note_missed, sustain_tick, sustain_broken, has_head_in_zone, has_tail_in_zone} !== 8'd0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000000", {hit_valid, hit_perfect, ghost_press, note_missed, sustain_tick, sustain_broken, has_head_in_zone, has_tail_in_zone});
    end
    tests++;
    if (streak !== 8'd0) begin fails++; $display("FAIL reset_streak: got %0d want 0", streak); end
    tests++;
    if (lane_rgb !== 6'd0) begin fails++; $display("FAIL reset_rgb: got %b want 000000", lane_rgb); end
    step(0, 2'b00, 0, 0);
    tests++;
    if (has_head_in_zone !== 1'b0 || lane_rgb !== 6'b010101) begin
      fails++;
      $display("FAIL reset_cleared: got head_zone=%b rgb=%b want 0 010101", has_head_in_zone, lane_rgb);
    end
    valid = 1'b0;
  endtask

  task automatic test_perfect_hit();
    do_reset();
    step(1, 2'b10, 0, 0);
    repeat (88) step(1, 2'b00, 0, 0);
    tests++;
    if (has_head_in_zone !== 1'b1) begin fails++; $display("FAIL perfect_in_zone: got %b want 1", has_head_in_zone); end
    step(0, 2'b00, 1, 0);
    tests++;
    if ({hit_valid, hit_perfect, streak} !== {1'b1, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL perfect_grade: got hv=%b hp=%b streak=%0d want 1 1 1", hit_valid, hit_perfect, streak);
    end
    valid = 1'b1;
    row = 10'd440;
    col = 10'd100;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'h3f) begin fails++; $display("FAIL perfect_white: got %b want 111111", lane_rgb); end
    step(1, 2'b00, 0, 0);
    row = 10'd445;
    col = 10'd117;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'b010101 || has_head_in_zone !== 1'b0) begin
      fails++;
      $display("FAIL perfect_removed: got rgb=%b head_zone=%b want 010101 0", lane_rgb, has_head_in_zone);
    end
    valid = 1'b0;
  endtask

  task automatic test_good_and_ghost();
    do_reset();
    step(1, 2'b10, 0, 0);
    repeat (84) step(1, 2'b00, 0, 0);
    step(0, 2'b00, 1, 0);
    tests++;
    if ({hit_valid, hit_perfect} !== 2'b10) begin
      fails++;
      $display("FAIL good_grade: got hv=%b hp=%b want 1 0", hit_valid, hit_perfect);
    end
    step(0, 2'b00, 1, 0);
    tests++;
    if ({ghost_press, hit_valid, streak} !== {1'b1, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL ghost_hit_head: got gp=%b hv=%b streak=%0d want 1 0 1", ghost_press, hit_valid, streak);
    end
    step(1, 2'b00, 0, 0);
    step(0, 2'b00, 1, 0);
    tests++;
    if ({ghost_press, hit_valid, streak} !== {1'b1, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL ghost_empty: got gp=%b hv=%b streak=%0d want 1 0 1", ghost_press, hit_valid, streak);
    end
  endtask

  task automatic load_sustain();
    do_reset();
    block_color = 6'b110000;
    step(1, 2'b10, 0, 1);
    repeat (3) step(1, 2'b00, 0, 1);
    repeat (6) step(1, 2'b01, 0, 1);
    repeat (77) step(1, 2'b00, 0, 1);
    step(0, 2'b00, 1, 1);
    tests++;
    if ({hit_valid, hit_perfect} !== 2'b11) begin
      fails++;
      $display("FAIL sustain_head: got hv=%b hp=%b want 1 1", hit_valid, hit_perfect);
    end
  endtask

  task automatic test_sustain();
    int ticks, seen, brk;
    load_sustain();
    ticks = 0;
    seen = 0;
    brk = 0;
    valid = 1'b1;
    row = 10'd465;
    col = 10'd117;
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b00, 0, 1);
      ticks += int'(sustain_tick);
      brk += int'(sustain_broken);
      step(0, 2'b00, 0, 1);
      brk += int'(sustain_broken);
      if (lane_rgb !== 6'b010101) seen++;
    end
    tests++;
    if (ticks != 6 || seen != 0 || brk != 0) begin
      fails++;
      $display("FAIL sustain_held: got ticks=%0d tails_at_93=%0d broken=%0d want 6 0 0", ticks, seen, brk);
    end
    load_sustain();
    ticks = 0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      step(1, 2'b00, 0, 1);
      ticks += int'(sustain_tick);
    end
    step(0, 2'b00, 0, 0);
    tests++;
    if (sustain_broken !== 1'b1) begin fails++; $display("FAIL sustain_broken: got %b want 1", sustain_broken); end
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b00, 0, 0);
      ticks += int'(sustain_tick);
      step(0, 2'b00, 0, 0);
      if (lane_rgb === block_color) seen++;
    end
    tests++;
    if (ticks != 2 || seen != 4) begin
      fails++;
      $display("FAIL sustain_release: got ticks=%0d tails_at_93=%0d want 2 4", ticks, seen);
    end
    valid = 1'b0;
  endtask

  task automatic test_streak();
    do_reset();
    step(1, 2'b10, 0, 0);
    repeat (92) step(1, 2'b10, 0, 0);
    for (int k = 0; k < 256; k++) begin
      step(0, 2'b00, 1, 0);
      if (k == 254) begin
        tests++;
        if (streak !== 8'd255) begin fails++; $display("FAIL streak_255: got %0d want 255", streak); end
      end
      if (k == 255) begin
        tests++;
        if ({hit_valid, streak} !== {1'b1, 8'd255}) begin
          fails++;
          $display("FAIL streak_saturate: got hv=%b streak=%0d want 1 255", hit_valid, streak);
        end
      end
      step(1, 2'b10, 0, 0);
    end
    repeat (3) step(1, 2'b10, 0, 0);
    tests++;
    if ({note_missed, streak} !== {1'b0, 8'd255}) begin
      fails++;
      $display("FAIL streak_no_miss: got nm=%b streak=%0d want 0 255", note_missed, streak);
    end
    step(1, 2'b10, 0, 0);
    tests++;
    if ({note_missed, streak} !== {1'b1, 8'd0}) begin
      fails++;
      $display("FAIL streak_miss: got nm=%b streak=%0d want 1 0", note_missed, streak);
    end
    step(0, 2'b00, 1, 0);
    step(0, 2'b00, 1, 0);
    step(1, 2'b10, 1, 0);
    tests++;
    if ({note_missed, hit_valid, streak} !== {1'b1, 1'b1, 8'd1}) begin
      fails++;
      $display("FAIL streak_miss_and_hit: got nm=%b hv=%b streak=%0d want 1 1 1", note_missed, hit_valid, streak);
    end
  endtask

  task automatic test_render();
    do_reset();
    lane_left_col = 10'd100;
    block_color = 6'b001110;
    step(1, 2'b10, 0, 0);
    repeat (10) step(1, 2'b00, 0, 0);
    valid = 1'b1;
    row = 10'd52;
    col = 10'd100;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'b001110) begin fails++; $display("FAIL render_head: got %b want 001110", lane_rgb); end
    valid = 1'b0;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'd0) begin fails++; $display("FAIL render_invalid: got %b want 000000", lane_rgb); end
    valid = 1'b1;
    col = 10'd134;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'b001110) begin fails++; $display("FAIL render_last_col: got %b want 001110", lane_rgb); end
    col = 10'd135;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'd0) begin fails++; $display("FAIL render_past_stripe: got %b want 000000", lane_rgb); end
    col = 10'd99;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'd0) begin fails++; $display("FAIL render_left_of_lane: got %b want 000000", lane_rgb); end
    row = 10'd480;
    col = 10'd100;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'd0) begin fails++; $display("FAIL render_below_lane: got %b want 000000", lane_rgb); end
    row = 10'd0;
    col = 10'd115;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'd0) begin fails++; $display("FAIL render_empty_side: got %b want 000000", lane_rgb); end
    col = 10'd116;
    step(0, 2'b00, 0, 0);
    tests++;
    if (lane_rgb !== 6'b010101) begin fails++; $display("FAIL render_empty_centre: got %b want 010101", lane_rgb); end
    valid = 1'b0;
  endtask

  task automatic test_random();
    bit adv, mk, bh;
    logic [1:0] dn;
    int r;
    logic [24:0] act, exp;
    do_reset();
    lane_left_col = 10'd100;
    bh = 1'b1;
    repeat (4000) begin
      adv = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      dn = r < 6 ? 2'b00 : r < 8 ? 2'b01 : 2'b10;
      mk = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 19) == 0) bh = !bh;
      valid = $urandom_range(0, 3) != 0;
      row = 10'($urandom_range(0, 499));
      col = 10'($urandom_range(90, 145));
      block_color = 6'($urandom);
      step(adv, dn, mk, bh);
      act = {hit_valid, hit_perfect, ghost_press, note_missed, sustain_tick, sustain_broken,
             has_head_in_zone, has_tail_in_zone, streak, lane_rgb, 3'b000};
      exp = {e_hv, e_hp, e_gp, e_nm, e_tk, e_br, zone_has(2, 1'b1), zone_has(1, 1'b0),
             8'(mstreak), e_rgb, 3'b000};
      tests++;
      if (act !== exp) begin
        fails++;
        if (fails < 20) $display("FAIL random_cycle: got %h want %h", act, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_perfect_hit();
    test_good_and_ghost();
    test_sustain();
    test_streak();
    test_render();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
